led_blink_code: RTL and testbench

Consumes the one-cycle tick strobe from the LED clock divider and drives a board LED with a blink code. Test logic (e.g. DDR3 bring-up calibration or status) hands over a small numeric code. The block flashes the LED that many times, each on/off phase one tick interval long, then holds a dark gap so consecutive codes stay readable by eye. All timing is in ticks; no internal long counter.

---
 rtl/led_blink_code.sv | 118 +++++++++++
 tb/tb_led_blink_code.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_code.sv
// led_blink_code: flashes a board LED a requested number of times, paced by
// an external tick strobe, then holds a dark gap so consecutive codes can be
// told apart by eye. All timing is counted in ticks.
//
// Handshake: a code transfers on a posedge where code_valid && code_ready.
// code_ready is high only in IDLE. While busy the producer must keep
// code_valid asserted until it is accepted; there is no queueing.
module led_blink_code #(
   parameter int CODE_WIDTH = 4,
   parameter int GAP_TICKS  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tick,
   input  logic                  code_valid,
   input  logic [CODE_WIDTH-1:0] code,
   output logic                  code_ready,
   output logic                  led,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            fsm_state
);

   localparam int GAP_W = $clog2(GAP_TICKS + 1);
   localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(GAP_TICKS);
   localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
   localparam logic [CODE_WIDTH-1:0] BLINK_ONE = CODE_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      ON   = 3'd2,
      OFF  = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t                state;
   logic [CODE_WIDTH-1:0] blink_cnt;
   logic [GAP_W-1:0]      gap_cnt;

   assign code_ready = (state == IDLE);
   assign fsm_state  = state;

   // Blink sequencer: every transition after acceptance waits for a tick, so
   // each lit or dark phase spans exactly one tick interval.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         led       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         blink_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            // Tick is deliberately ignored here; SYNC waits for a fresh one
            // so the first lit phase is a full interval.
            IDLE: begin
               led <= 1'b0;
               if (code_valid) begin
                  blink_cnt <= code;
                  busy      <= 1'b1;
                  state     <= SYNC;
               end
            end
            SYNC: begin
               if (tick) begin
                  if (blink_cnt != '0) begin
                     led   <= 1'b1;
                     state <= ON;
                  end else begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end
               end
            end
            ON: begin
               if (tick) begin
                  led   <= 1'b0;
                  state <= OFF;
               end
            end
            // blink_cnt holds the blinks still owed including the one just
            // shown, so it is only decremented while above one.
            OFF: begin
               if (tick) begin
                  if (blink_cnt > BLINK_ONE) begin
                     blink_cnt <= blink_cnt - BLINK_ONE;
                     led       <= 1'b1;
                     state     <= ON;
                  end else begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (gap_cnt <= GAP_ONE) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - GAP_ONE;
                  end
               end
            end
            default: begin
               led   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_code.sv
// tb_led_blink_code: directed scenarios for led_blink_code. Expected events
// (acceptance, led edges, done pulses) are queued with the cycle at which
// they must be seen; a monitor pops and compares as the DUT produces them.
module tb_led_blink_code;

   localparam int CW = 4;
   localparam int GT = 4;
   localparam int W  = 32;

   localparam logic [3:0] EV_ACC  = 4'd1;
   localparam logic [3:0] EV_RISE = 4'd2;
   localparam logic [3:0] EV_FALL = 4'd3;
   localparam logic [3:0] EV_DONE = 4'd4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          tick = 1'b0;
   logic          code_valid = 1'b0;
   logic [CW-1:0] code = '0;
   logic          code_ready;
   logic          led;
   logic          busy;
   logic          done;
   logic [2:0]    fsm_state;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   int tick_base = 0;
   int tick_period = 1;
   bit tick_en = 1'b0;

   logic prev_led = 1'b0;
   logic prev_busy = 1'b0;

   led_blink_code #(.CODE_WIDTH(CW), .GAP_TICKS(GT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .code_valid (code_valid),
      .code       (code),
      .code_ready (code_ready),
      .led        (led),
      .busy       (busy),
      .done       (done),
      .fsm_state  (fsm_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] ev(input logic [3:0] t, input int c);
      return {t, c[27:0]};
   endfunction

   // Posedge index of the j-th tick strictly after posedge a.
   function automatic int tick_at(input int a, input int j);
      int k0;
      k0 = tick_base;
      if (a >= tick_base)
         k0 = tick_base + ((a - tick_base) / tick_period + 1) * tick_period;
      return k0 + (j - 1) * tick_period;
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected event list for one complete code sequence accepted at posedge a.
   task automatic expect_seq(input int a, input int n);
      exp_q.push_back(ev(EV_ACC, a));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(ev(EV_RISE, tick_at(a, 1 + 2 * i)));
         exp_q.push_back(ev(EV_FALL, tick_at(a, 2 + 2 * i)));
      end
      exp_q.push_back(ev(EV_DONE, tick_at(a, 1 + 2 * n + GT)));
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no done within %0d cycles (cycle %0d)", name, budget, cyc);
      end
   endtask

   // ---------------- tick driver ----------------
   // Decides tick for the upcoming posedge (index cyc+1), slightly after the
   // falling edge so it sees any schedule change made at that edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         tick = tick_en && (cyc + 1 >= tick_base) &&
                (((cyc + 1 - tick_base) % tick_period) == 0);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic mon(input logic [3:0] t);
      logic [W-1:0] got;
      logic [W-1:0] want;
      got = ev(t, cyc);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: got unexpected type %0d at cycle %0d, queue empty", t, cyc);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL event: got type %0d cycle %0d expected type %0d cycle %0d",
                     got[31:28], got[27:0], want[31:28], want[27:0]);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && prev_busy === 1'b0) mon(EV_ACC);
         if (led === 1'b1 && prev_led === 1'b0) mon(EV_RISE);
         if (led === 1'b0 && prev_led === 1'b1) mon(EV_FALL);
         if (done === 1'b1) mon(EV_DONE);
         prev_led  = led;
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int a;
      int g;
      int r;

      // Reset held with a code offered: nothing may start.
      reset_n    = 1'b0;
      code_valid = 1'b1;
      code       = 4'd0;
      repeat (3) begin
         @(negedge clk);
         check_bit("rst_led", led, 1'b0);
         check_bit("rst_busy", busy, 1'b0);
         check_bit("rst_done", done, 1'b0);
      end

      // Release reset; code 0 is accepted on the next posedge, with a
      // coincident tick that must be ignored.
      reset_n = 1'b1;
      check_bit("post_rst_ready", code_ready, 1'b1);
      check_bit("post_rst_busy", busy, 1'b0);
      a           = cyc + 1;
      tick_base   = a;
      tick_period = 10;
      tick_en     = 1'b1;
      expect_seq(a, 0);
      @(negedge clk);
      code_valid = 1'b0;
      check_bit("accept_busy", busy, 1'b1);
      check_bit("accept_ready", code_ready, 1'b0);
      wait_done("code0", 200);
      check_bit("done_busy", busy, 1'b0);
      check_bit("done_ready", code_ready, 1'b1);
      @(negedge clk);
      check_bit("done_pulse_end", done, 1'b0);

      // code 3, tick every 10 cycles.
      repeat (3) @(negedge clk);
      code        = 4'd3;
      code_valid  = 1'b1;
      a           = cyc + 1;
      tick_base   = a + 1;
      tick_period = 10;
      expect_seq(a, 3);
      @(negedge clk);
      code_valid = 1'b0;
      wait_done("code3", 300);

      // code 15, tick every 5 cycles, tick coincident with the transfer.
      repeat (2) @(negedge clk);
      code        = 4'd15;
      code_valid  = 1'b1;
      a           = cyc + 1;
      tick_base   = a;
      tick_period = 5;
      expect_seq(a, 15);
      @(negedge clk);
      code_valid = 1'b0;
      wait_done("code15", 400);

      // code 2 held valid continuously, tick every 3 cycles: second
      // transfer lands in the done cycle.
      repeat (2) @(negedge clk);
      code        = 4'd2;
      code_valid  = 1'b1;
      a           = cyc + 1;
      tick_base   = a + 1;
      tick_period = 3;
      expect_seq(a, 2);
      g = tick_at(a, 1 + 2 * 2 + GT);
      expect_seq(g + 1, 2);
      wait_done("hold_first", 100);
      wait_done("hold_second", 100);
      code_valid = 1'b0;
      repeat (10) @(negedge clk);
      check_bit("hold_idle", busy, 1'b0);

      // code 5, reset during the second lit phase, then code 1.
      code        = 4'd5;
      code_valid  = 1'b1;
      a           = cyc + 1;
      tick_base   = a + 1;
      tick_period = 4;
      r           = tick_at(a, 3) + 2;
      exp_q.push_back(ev(EV_ACC, a));
      exp_q.push_back(ev(EV_RISE, tick_at(a, 1)));
      exp_q.push_back(ev(EV_FALL, tick_at(a, 2)));
      exp_q.push_back(ev(EV_RISE, tick_at(a, 3)));
      exp_q.push_back(ev(EV_FALL, r));
      @(negedge clk);
      code_valid = 1'b0;
      while (cyc < r - 1) @(negedge clk);
      check_bit("pre_rst_led", led, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      check_bit("midrst_led", led, 1'b0);
      check_bit("midrst_busy", busy, 1'b0);
      check_bit("midrst_done", done, 1'b0);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      check_bit("after_rst_busy", busy, 1'b0);

      code       = 4'd1;
      code_valid = 1'b1;
      a          = cyc + 1;
      expect_seq(a, 1);
      @(negedge clk);
      code_valid = 1'b0;
      wait_done("code1", 100);

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty: got %0d pending events expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
